instr_prefetch: RTL and testbench

Instruction prefetch unit upstream of the five-stage MIPS pipeline's IF/ID register. Issues word addresses to the synchronous instruction RAM, buffers returned instructions with their PC+4 in a small FIFO, and presents them to decode under a valid/ready handshake. Branch and jump redirects from ID flush the buffer and drop in-flight fetches. This decouples ID stalls from instruction-memory timing.

---
 rtl/instr_prefetch_if.sv | 23 ++
 rtl/instr_prefetch.sv | 98 +++++++++
 tb/tb_instr_prefetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_if.sv
// rtl/instr_prefetch_if.sv - imem request/response and decode handshake signals of the prefetch unit
interface instr_prefetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc4;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc4, halted,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc4, halted,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch FIFO between instruction RAM and ID with redirect flush
// Optional feature macro: PREFETCH_HALT_EN (stop fetching after an all-ones instruction word).
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  instr_prefetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetchPc;
  logic [31:0]   rspPc4;
  logic          rspPending;
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [CW-1:0] count;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pc4Mem   [DEPTH];
  logic          haltedQ;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the in-flight word so a returning response always has a free slot.
  assign pop       = bus.instr_valid && bus.id_ready;
  assign push      = rspPending && !haltedQ;
  assign occupancy = {1'b0, count} + (CW+1)'(rspPending) - (CW+1)'(pop);
  assign issue     = !haltedQ && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetchPc >> 2;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = instrMem[headPtr];
  assign bus.instr_pc4   = pc4Mem[headPtr];
  assign bus.halted      = haltedQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc    <= RESET_PC;
      rspPc4     <= '0;
      rspPending <= 1'b0;
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
    end else if (bus.redirect_valid) begin
      fetchPc    <= bus.redirect_pc & ~32'h3;
      rspPending <= 1'b0;
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
    end else begin
      if (issue) begin
        fetchPc    <= fetchPc + 32'd4;
        rspPc4     <= fetchPc + 32'd4;
        rspPending <= 1'b1;
      end else begin
        rspPending <= 1'b0;
      end

      if (push) begin
        instrMem[tailPtr] <= bus.imem_rdata;
        pc4Mem[tailPtr]   <= rspPc4;
        tailPtr           <= nextPtr(tailPtr);
      end
      if (pop) begin
        headPtr <= nextPtr(headPtr);
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      fifoOverflow: assert (!(push && !pop && count == CW'(DEPTH)));
    end
  end

`ifdef PREFETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || bus.redirect_valid) begin
      haltedQ <= 1'b0;
    end else if (push && bus.imem_rdata == 32'hFFFF_FFFF) begin
      haltedQ <= 1'b1;
    end
  end
`else
  assign haltedQ = 1'b0;
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - scoreboard bench for instr_prefetch: directed timing cases plus random stalls/redirects/resets
module tb_instr_prefetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } expT;

  logic clk = 1'b0;
  logic rst_n;
  instr_prefetch_if bus();

  int          tests = 0;
  int          fails = 0;
  int          popsSeen = 0;
  expT         expQ[$];
  logic [31:0] nextModelPc;
  logic [31:0] haltAddr = 32'hFFFF_FFFF;

  instr_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramWord(input logic [31:0] wordAddr, input logic [31:0] hAddr);
    return (wordAddr == hAddr) ? 32'hFFFF_FFFF : wordAddr;
  endfunction

  // Synchronous RAM: data for a request appears the following cycle; otherwise garbage.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? ramWord(bus.imem_addr, haltAddr) : $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic extendModel();
    expT e;
    e.instr = ramWord(nextModelPc >> 2, haltAddr);
    e.pc4   = nextModelPc + 32'd4;
    expQ.push_back(e);
    nextModelPc = nextModelPc + 32'd4;
  endtask

  // The delivered stream from any restart point is simply consecutive words from that PC.
  task automatic restart(input logic [31:0] pc);
    expQ.delete();
    nextModelPc = pc & ~32'h3;
    for (int i = 0; i < 16; i++) extendModel();
  endtask

  always @(negedge clk) begin
    expT e;
    if (rst_n && bus.instr_valid && bus.id_ready && !bus.redirect_valid) begin
      while (expQ.size() < 8) extendModel();
      e = expQ.pop_front();
      check("deliver_instr", bus.instr, e.instr);
      check("deliver_pc4", bus.instr_pc4, e.pc4);
      popsSeen++;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic doReset(input logic ready);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = ready;
    restart(RESET_PC);
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int          issues;
    int          popsMark;
    logic [31:0] maxAddr;
    int          r;

    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    nextCycle();

    // Reset state and sequential streaming.
    doReset(1'b1);
    toNeg();
    checkBit("reset_req", bus.imem_req, 1'b1);
    checkBit("reset_halted", bus.halted, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) toNeg();
      check("stream_addr", bus.imem_addr, RESET_PC / 4 + 32'(i));
      checkBit("stream_valid", bus.instr_valid, i >= 2);
      nextCycle();
    end

    // Stall fills the FIFO, then gap-free release.
    doReset(1'b0);
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      toNeg();
      if (bus.imem_req) issues++;
      nextCycle();
    end
    toNeg();
    check("stall_issues", 32'(issues), 32'd4);
    checkBit("stall_req_off", bus.imem_req, 1'b0);
    checkBit("stall_valid", bus.instr_valid, 1'b1);
    nextCycle();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      toNeg();
      checkBit("release_no_gap", bus.instr_valid, 1'b1);
      nextCycle();
    end

    // Redirect with 3 queued and one in flight.
    doReset(1'b0);
    for (int i = 0; i < 4; i++) nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0102;
    bus.id_ready       = 1'b1;
    restart(32'h0000_0102);
    toNeg();
    checkBit("redir_no_req", bus.imem_req, 1'b0);
    nextCycle();
    bus.redirect_valid = 1'b0;
    toNeg();
    checkBit("redir_req", bus.imem_req, 1'b1);
    check("redir_addr", bus.imem_addr, 32'h40);
    checkBit("redir_valid_r1", bus.instr_valid, 1'b0);
    nextCycle();
    toNeg();
    checkBit("redir_valid_r2", bus.instr_valid, 1'b0);
    nextCycle();
    toNeg();
    checkBit("redir_valid_r3", bus.instr_valid, 1'b1);
    check("redir_pc4", bus.instr_pc4, 32'h104);
    for (int i = 0; i < 4; i++) nextCycle();

    // Redirect coinciding with push and pop while the FIFO is near full.
    doReset(1'b0);
    for (int i = 0; i < 6; i++) nextCycle();
    bus.id_ready = 1'b1;
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    restart(32'h0000_0200);
    nextCycle();
    bus.redirect_valid = 1'b0;
    toNeg();
    checkBit("full_redir_empty", bus.instr_valid, 1'b0);
    for (int i = 0; i < 6; i++) nextCycle();

    // One-cycle reset in the middle of a stream.
    doReset(1'b1);
    for (int i = 0; i < 10; i++) nextCycle();
    rst_n = 1'b0;
    restart(RESET_PC);
    nextCycle();
    rst_n = 1'b1;
    toNeg();
    checkBit("midrst_valid0", bus.instr_valid, 1'b0);
    check("midrst_addr", bus.imem_addr, RESET_PC >> 2);
    nextCycle();
    toNeg();
    checkBit("midrst_stale_dropped", bus.instr_valid, 1'b0);
    nextCycle();
    toNeg();
    checkBit("midrst_valid2", bus.instr_valid, 1'b1);
    nextCycle();

    // 32-bit PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    restart(32'hFFFF_FFF8);
    nextCycle();
    bus.redirect_valid = 1'b0;
    popsMark = popsSeen;
    for (int i = 0; i < 10; i++) nextCycle();
    checkBit("wrap_progress", (popsSeen - popsMark) >= 6, 1'b1);

`ifdef PREFETCH_HALT_EN
    haltAddr = 32'd3;
    doReset(1'b1);
    popsMark = popsSeen;
    maxAddr  = '0;
    for (int i = 0; i < 12; i++) begin
      toNeg();
      if (bus.imem_req && bus.imem_addr > maxAddr) maxAddr = bus.imem_addr;
      nextCycle();
    end
    toNeg();
    check("halt_max_addr", maxAddr, 32'd4);
    checkBit("halt_flag", bus.halted, 1'b1);
    checkBit("halt_no_req", bus.imem_req, 1'b0);
    checkBit("halt_drained", bus.instr_valid, 1'b0);
    check("halt_drain_count", 32'(popsSeen - popsMark), 32'd4);
    haltAddr = 32'hFFFF_FFFF;
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    restart(32'h0);
    nextCycle();
    bus.redirect_valid = 1'b0;
    toNeg();
    checkBit("halt_cleared", bus.halted, 1'b0);
    checkBit("halt_restart_req", bus.imem_req, 1'b1);
    check("halt_restart_addr", bus.imem_addr, 32'h0);
    nextCycle();
`endif

    // Random stalls, redirects and resets against the stream model.
    popsMark = popsSeen;
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      rst_n              = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (r < 2) begin
        rst_n = 1'b0;
        restart(RESET_PC);
      end else if (r < 10) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
        restart(bus.redirect_pc);
      end
    end
    nextCycle();
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    for (int i = 0; i < 5; i++) nextCycle();
    checkBit("random_progress", (popsSeen - popsMark) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
